// File: rtl/ddr3_app_sequencer_if.sv
// Bus bundles for the DDR3 app sequencer: MCU request/response port and MIG app port.
// master drives requests (MCU) or commands (sequencer); slave is the responding side.
interface ddr3_mcu_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_rw;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [DATA_WIDTH-1:0] i_req_wdata;
    logic [MASK_WIDTH-1:0] i_req_mask;
    logic                  o_rsp_valid;
    logic [DATA_WIDTH-1:0] o_rsp_rdata;
    logic                  o_rsp_error;

    modport master (
        output i_req_valid, i_req_rw, i_req_addr, i_req_wdata, i_req_mask,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_error
    );

    modport slave (
        input  i_req_valid, i_req_rw, i_req_addr, i_req_wdata, i_req_mask,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_error
    );
endinterface

interface ddr3_app_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
);
    logic                  i_init_calib_complete;
    logic [ADDR_WIDTH-1:0] o_app_addr;
    logic [2:0]            o_app_cmd;
    logic                  o_app_en;
    logic                  i_app_rdy;
    logic [DATA_WIDTH-1:0] o_app_wdf_data;
    logic [MASK_WIDTH-1:0] o_app_wdf_mask;
    logic                  o_app_wdf_wren;
    logic                  o_app_wdf_end;
    logic                  i_app_wdf_rdy;
    logic [DATA_WIDTH-1:0] i_app_rd_data;
    logic                  i_app_rd_data_valid;
    logic                  i_app_rd_data_end;

    modport master (
        output o_app_addr, o_app_cmd, o_app_en, o_app_wdf_data, o_app_wdf_mask,
               o_app_wdf_wren, o_app_wdf_end,
        input  i_init_calib_complete, i_app_rdy, i_app_wdf_rdy, i_app_rd_data,
               i_app_rd_data_valid, i_app_rd_data_end
    );

    modport slave (
        input  o_app_addr, o_app_cmd, o_app_en, o_app_wdf_data, o_app_wdf_mask,
               o_app_wdf_wren, o_app_wdf_end,
        output i_init_calib_complete, i_app_rdy, i_app_wdf_rdy, i_app_rd_data,
               i_app_rd_data_valid, i_app_rd_data_end
    );
endinterface

// File: rtl/ddr3_app_sequencer.sv
// Single-outstanding MCU-to-MIG app sequencer: one 128-bit read or write at a time,
// registered outputs, and a per-state watchdog that turns a stall into an error response.
module ddr3_app_sequencer #(
    parameter int ADDR_WIDTH     = 28,
    parameter int DATA_WIDTH     = 128,
    parameter int MASK_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk_166M66,
    input  logic        mcu_sys_rst_n,
    ddr3_mcu_if.slave   mcu,
    ddr3_app_if.master  app
);
    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_WIDTH-1:0] WD_ONE  = WD_WIDTH'(1);
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        IDLE, W_DATA, W_CMD, R_CMD, R_WAIT, RESP
    } state_t;

    state_t                state_reg, state_next;
    logic [WD_WIDTH-1:0]   wd_reg, wd_next;
    logic                  req_ready_reg, req_ready_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic                  rsp_error_reg, rsp_error_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic [ADDR_WIDTH-1:0] app_addr_reg, app_addr_next;
    logic [2:0]            app_cmd_reg, app_cmd_next;
    logic                  app_en_reg, app_en_next;
    logic [DATA_WIDTH-1:0] wdf_data_reg, wdf_data_next;
    logic [MASK_WIDTH-1:0] wdf_mask_reg, wdf_mask_next;
    logic                  wdf_wren_reg, wdf_wren_next;
    logic                  wdf_end_reg, wdf_end_next;
    logic                  fire_timeout;

    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) begin
            state_reg     <= IDLE;
            wd_reg        <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_error_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            app_addr_reg  <= '0;
            app_cmd_reg   <= '0;
            app_en_reg    <= 1'b0;
            wdf_data_reg  <= '0;
            wdf_mask_reg  <= '0;
            wdf_wren_reg  <= 1'b0;
            wdf_end_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wd_reg        <= wd_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_error_reg <= rsp_error_next;
            rsp_rdata_reg <= rsp_rdata_next;
            app_addr_reg  <= app_addr_next;
            app_cmd_reg   <= app_cmd_next;
            app_en_reg    <= app_en_next;
            wdf_data_reg  <= wdf_data_next;
            wdf_mask_reg  <= wdf_mask_next;
            wdf_wren_reg  <= wdf_wren_next;
            wdf_end_reg   <= wdf_end_next;
        end
    end

    // Strobes default low so every exit (handshake or timeout) drops them on the next edge.
    always_comb begin
        state_next     = state_reg;
        wd_next        = wd_reg;
        req_ready_next = 1'b0;
        rsp_valid_next = 1'b0;
        rsp_error_next = rsp_error_reg;
        rsp_rdata_next = rsp_rdata_reg;
        app_addr_next  = app_addr_reg;
        app_cmd_next   = app_cmd_reg;
        app_en_next    = 1'b0;
        wdf_data_next  = wdf_data_reg;
        wdf_mask_next  = wdf_mask_reg;
        wdf_wren_next  = 1'b0;
        wdf_end_next   = 1'b0;
        fire_timeout   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (mcu.i_req_valid && req_ready_reg) begin
                    app_addr_next = mcu.i_req_addr;
                    wdf_data_next = mcu.i_req_wdata;
                    wdf_mask_next = mcu.i_req_mask;
                    wd_next       = '0;
                    if (mcu.i_req_rw) begin
                        state_next    = W_DATA;
                        app_cmd_next  = CMD_WRITE;
                        wdf_wren_next = 1'b1;
                        wdf_end_next  = 1'b1;
                    end else begin
                        state_next   = R_CMD;
                        app_cmd_next = CMD_READ;
                        app_en_next  = 1'b1;
                    end
                end else begin
                    req_ready_next = app.i_init_calib_complete;
                end
            end
            W_DATA: begin
                if (app.i_app_wdf_rdy) begin
                    state_next  = W_CMD;
                    app_en_next = 1'b1;
                    wd_next     = '0;
                end else if (wd_reg == WD_LAST) begin
                    fire_timeout = 1'b1;
                end else begin
                    wdf_wren_next = 1'b1;
                    wdf_end_next  = 1'b1;
                    wd_next       = wd_reg + WD_ONE;
                end
            end
            W_CMD: begin
                if (app.i_app_rdy) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_error_next = 1'b0;
                    rsp_rdata_next = '0;
                    wd_next        = '0;
                end else if (wd_reg == WD_LAST) begin
                    fire_timeout = 1'b1;
                end else begin
                    app_en_next = 1'b1;
                    wd_next     = wd_reg + WD_ONE;
                end
            end
            R_CMD: begin
                if (app.i_app_rdy) begin
                    state_next = R_WAIT;
                    wd_next    = '0;
                end else if (wd_reg == WD_LAST) begin
                    fire_timeout = 1'b1;
                end else begin
                    app_en_next = 1'b1;
                    wd_next     = wd_reg + WD_ONE;
                end
            end
            R_WAIT: begin
                // A beat without end is not the final beat and is ignored.
                if (app.i_app_rd_data_valid && app.i_app_rd_data_end) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_error_next = 1'b0;
                    rsp_rdata_next = app.i_app_rd_data;
                    wd_next        = '0;
                end else if (wd_reg == WD_LAST) begin
                    fire_timeout = 1'b1;
                end else begin
                    wd_next = wd_reg + WD_ONE;
                end
            end
            RESP: begin
                state_next     = IDLE;
                req_ready_next = app.i_init_calib_complete;
                wd_next        = '0;
            end
            default: begin
                state_next = IDLE;
                wd_next    = '0;
            end
        endcase

        if (fire_timeout) begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_error_next = 1'b1;
            rsp_rdata_next = '0;
            wd_next        = '0;
        end
    end

    assign mcu.o_req_ready    = req_ready_reg;
    assign mcu.o_rsp_valid    = rsp_valid_reg;
    assign mcu.o_rsp_rdata    = rsp_rdata_reg;
    assign mcu.o_rsp_error    = rsp_error_reg;
    assign app.o_app_addr     = app_addr_reg;
    assign app.o_app_cmd      = app_cmd_reg;
    assign app.o_app_en       = app_en_reg;
    assign app.o_app_wdf_data = wdf_data_reg;
    assign app.o_app_wdf_mask = wdf_mask_reg;
    assign app.o_app_wdf_wren = wdf_wren_reg;
    assign app.o_app_wdf_end  = wdf_end_reg;
endmodule

// File: doc/ddr3_app_sequencer.md
# ddr3_app_sequencer

Single-outstanding request sequencer between the MCU memory port and the MIG 7-series user (app) interface of the DDR3 controller wrapper. It accepts one 128-bit read or write request at a time and drives the MIG app command and write-data handshakes. It captures the returned read beat and hands a one-cycle response back to the MCU, with a watchdog that reports an error instead of hanging. It runs entirely in the MIG ui_clk domain (166.66 MHz).

## Interface
- ADDR_WIDTH, 28, MIG app_addr width (bank/row/column)
- DATA_WIDTH, 128, app data width (16-bit PHY x BL8)
- MASK_WIDTH, 16, DATA_WIDTH/8, app_wdf_mask width (1 = byte masked)
- TIMEOUT_CYCLES, 1023, max cycles any wait state may last before error
- clk_166M66  in  1  ui_clk from MIG; sole clock
- mcu_sys_rst_n  in  1  asynchronous, active-low reset
- i_init_calib_complete  in  1  MIG calibration done
- i_req_valid / o_req_ready  in/out  1  request handshake
- i_req_rw  in  1  1 = write, 0 = read
- i_req_addr  in  ADDR_WIDTH  request address
- i_req_wdata / i_req_mask  in  DATA_WIDTH / MASK_WIDTH  write payload
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_rdata  out  DATA_WIDTH  read data
- o_rsp_error  out  1  timeout flag, qualified by o_rsp_valid
- o_app_addr  out  ADDR_WIDTH
- o_app_cmd  out  3  000 = write, 001 = read
- o_app_en  out  1
- i_app_rdy  in  1
- o_app_wdf_data / o_app_wdf_mask  out  DATA_WIDTH / MASK_WIDTH
- o_app_wdf_wren / o_app_wdf_end  out  1
- i_app_wdf_rdy  in  1
- i_app_rd_data  in  DATA_WIDTH
- i_app_rd_data_valid / i_app_rd_data_end  in  1

## Operation
- States are IDLE, W_DATA, W_CMD, R_CMD, R_WAIT and RESP. All outputs are registered.
- IDLE
  - o_req_ready = i_init_calib_complete.
  - On i_req_valid & o_req_ready, latch addr, rw, wdata and mask, then go to W_DATA (write) or R_CMD (read).
- W_DATA
  - Hold o_app_wdf_wren = o_app_wdf_end = 1 with the latched data and mask.
  - On i_app_wdf_rdy, drop both and go to W_CMD.
- W_CMD
  - Hold o_app_en = 1 and o_app_cmd = 000 with the latched address.
  - On i_app_rdy, go to RESP.
- R_CMD
  - Hold o_app_en = 1 and o_app_cmd = 001.
  - On i_app_rdy, go to R_WAIT.
- R_WAIT
  - On i_app_rd_data_valid & i_app_rd_data_end, capture i_app_rd_data into o_rsp_rdata and go to RESP.
  - A valid beat without end is ignored.
- RESP
  - o_rsp_valid = 1 for exactly one cycle, then return to IDLE.
  - The MCU cannot backpressure the response.
- Write responses
  - o_rsp_rdata = 0 and o_rsp_error = 0.
  - o_rsp_rdata keeps its last value until the next response.
- Watchdog
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and clears on every state entry.
  - It increments in W_DATA, W_CMD, R_CMD and R_WAIT.
  - If TIMEOUT_CYCLES cycles pass without the exit condition:
    - drop o_app_en and o_app_wdf_wren/end;
    - set o_rsp_error = 1 and o_rsp_rdata = 0;
    - go to RESP.
- A read beat arriving in IDLE or RESP (late data after a timeout) is discarded. It is never presented as a response.
- If i_init_calib_complete deasserts mid-transaction, the transaction still completes or times out. o_req_ready then stays 0 until calibration returns.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE;
  - every output = 0, including o_app_en, o_app_wdf_wren, o_req_ready and o_rsp_rdata;
  - watchdog = 0.
- Write latency with rdy signals already high:
  - accept at cycle 0;
  - wdf_wren high at cycle 1;
  - app_en high at cycle 2;
  - o_rsp_valid at cycle 3.
- Read latency with app_rdy high:
  - app_en high at cycle 1;
  - R_WAIT from cycle 2;
  - o_rsp_valid one cycle after the cycle in which valid & end is sampled.
- o_app_en and o_app_wdf_wren remain asserted with stable address, command and data until their rdy is sampled high. They deassert in the cycle after the handshake.
- Throughput: o_req_ready reasserts the cycle after RESP, so the minimum spacing is 4 cycles per write.
- Simultaneous exit condition and timeout in the same cycle: the exit condition wins, so no error is reported.

## Test plan
- Calibration gating: i_init_calib_complete = 0 with i_req_valid = 1 -> o_req_ready = 0 and no app_en. Raise calibration -> accepted next cycle.
- Write, rdy always high, addr 0x0000100, data 0x0123…CDEF, mask 0x0000 -> wdf_wren at +1, app_en with cmd 000 at +2, o_rsp_valid at +3 with error 0.
- Read with app_rdy held low 5 cycles and data returned 20 cycles later as 0xA5A5…A5 -> app_en held 6 cycles with stable address, then rsp_rdata = 0xA5A5…A5 and error 0.
- Timeout: TIMEOUT_CYCLES = 16, read with data never returned -> o_rsp_valid with error = 1 and rdata = 0 after 16 cycles in R_WAIT. A late beat injected afterwards -> no response.
- Backpressure on the write path: i_app_wdf_rdy low 3 cycles, then i_app_rdy low 2 cycles -> wren/end held 4 cycles, app_en held 3 cycles, a single response.
- Reset mid-read in R_CMD -> o_app_en = 0 immediately. After release, the next request completes normally.
